// File: rtl/pipeline_hazard_sequencer_pkg.sv
// Shared types for the pipeline hazard sequencer: state encoding, register
// number width, shadow scoreboard entry and the NOP entry written on squash.
package pipeline_hazard_sequencer_pkg;

    localparam int REG_W = 5;
    localparam int CNT_W = 2;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        FLUSH    = 2'd1,
        MEM_WAIT = 2'd2
    } state_t;

    typedef struct packed {
        logic             valid;
        logic [REG_W-1:0] dest;
        logic             wb_en;
        logic             mem_read;
    } sb_entry_t;

    // A squashed slot carries no write-back and no load, so it never hits.
    localparam sb_entry_t SB_NOP = '{valid: 1'b0, dest: '0, wb_en: 1'b0, mem_read: 1'b0};

endpackage

// File: rtl/pipeline_hazard_sequencer_hazard_compare.sv
// Compares the ID-stage source registers against one in-flight scoreboard entry.
// Register 0 is hardwired, so a write to it never creates a dependency.
module hazard_compare
    import pipeline_hazard_sequencer_pkg::*;
(
    input  sb_entry_t        entry,
    input  logic [REG_W-1:0] src1,
    input  logic [REG_W-1:0] src2,
    input  logic             src2_used,
    output logic             hit
);

    always_comb begin
        hit = entry.valid && entry.wb_en && (entry.dest != '0) &&
              ((entry.dest == src1) || (src2_used && (entry.dest == src2)));
    end

endmodule

// File: rtl/pipeline_hazard_sequencer.sv
// Hazard/flush/freeze sequencer beside the ID stage.
//   state    | meaning
//   RUN      | normal flow, stalls on data hazards
//   FLUSH    | squashing younger instructions after a taken branch
//   MEM_WAIT | data memory busy, whole pipeline frozen
module pipeline_hazard_sequencer
    import pipeline_hazard_sequencer_pkg::*;
#(
    parameter bit FORWARD_EN   = 1'b1,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             id_valid,
    input  logic [REG_W-1:0] id_src1,
    input  logic [REG_W-1:0] id_src2,
    input  logic             id_is_imm,
    input  logic             id_mem_write,
    input  logic             id_branch,
    input  logic [REG_W-1:0] id_dest,
    input  logic             id_wb_en,
    input  logic             id_mem_read,
    input  logic             exe_br_taken,
    input  logic             mem_busy,
    output logic             hold_pc,
    output logic             bubble_ex,
    output logic             flush_front,
    output logic             freeze_all,
    output logic [1:0]       state
);

    localparam logic [CNT_W-1:0] FLUSH_LOAD  = CNT_W'(FLUSH_CYCLES - 1);
    localparam bit               MULTI_FLUSH = (FLUSH_CYCLES > 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, remain;
    logic             pending_q, pending_d;
    sb_entry_t        ex_q, mem_q, ex_d;
    logic             src2_used, hit_ex, hit_mem, hazard;

    hazard_compare u_cmp_ex (
        .entry     (ex_q),
        .src1      (id_src1),
        .src2      (id_src2),
        .src2_used (src2_used),
        .hit       (hit_ex)
    );

    hazard_compare u_cmp_mem (
        .entry     (mem_q),
        .src1      (id_src1),
        .src2      (id_src2),
        .src2_used (src2_used),
        .hit       (hit_mem)
    );

    always_comb begin
        src2_used   = !id_is_imm || id_mem_write || id_branch;
        hazard      = FORWARD_EN ? (hit_ex && ex_q.mem_read) : (hit_ex || hit_mem);
        freeze_all  = mem_busy || ((state_q == MEM_WAIT) && mem_busy);
        flush_front = !freeze_all && (exe_br_taken || (state_q == FLUSH) || pending_q);
        bubble_ex   = hazard && id_valid && !freeze_all && !flush_front;
        hold_pc     = bubble_ex || freeze_all;
        state       = state_q;
        ex_d        = (bubble_ex || flush_front) ? SB_NOP :
                      '{valid: id_valid, dest: id_dest, wb_en: id_wb_en, mem_read: id_mem_read};
    end

    // A FLUSH interrupted by a freeze is parked as pending; the count it keeps
    // includes the frozen slot, which the release cycle then consumes.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        pending_d = pending_q;
        remain    = '0;

        if (freeze_all) begin
            if (exe_br_taken || (state_q == FLUSH)) pending_d = 1'b1;
        end else if (flush_front) begin
            pending_d = 1'b0;
        end

        case (state_q)
            RUN: begin
                if (mem_busy) begin
                    state_d = MEM_WAIT;
                end else if (exe_br_taken && MULTI_FLUSH) begin
                    state_d = FLUSH;
                    cnt_d   = FLUSH_LOAD;
                end
            end
            FLUSH: begin
                if (mem_busy) begin
                    state_d = MEM_WAIT;
                end else begin
                    if (cnt_q != '0) cnt_d = cnt_q - CNT_W'(1);
                    if (cnt_q <= CNT_W'(1)) state_d = RUN;
                end
            end
            MEM_WAIT: begin
                if (!mem_busy) begin
                    if (pending_q || exe_br_taken) begin
                        remain  = (cnt_q != '0) ? (cnt_q - CNT_W'(1)) : FLUSH_LOAD;
                        cnt_d   = remain;
                        state_d = (remain != '0) ? FLUSH : RUN;
                    end else begin
                        state_d = RUN;
                    end
                end
            end
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= RUN;
            cnt_q     <= '0;
            pending_q <= 1'b0;
            ex_q      <= SB_NOP;
            mem_q     <= SB_NOP;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pending_q <= pending_d;
            if (!freeze_all) begin
                mem_q <= ex_q;
                ex_q  <= ex_d;
            end
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_sequencer.sv
// Bench for pipeline_hazard_sequencer: three instances (forwarding, no forwarding,
// three-slot flush) share one stimulus bus; each scenario observes one of them.
module tb_pipeline_hazard_sequencer;

    typedef struct packed {
        logic       rst;
        logic       valid;
        logic [4:0] s1;
        logic [4:0] s2;
        logic       imm;
        logic       mw;
        logic       br;
        logic [4:0] dest;
        logic       wb;
        logic       mr;
        logic       brt;
        logic       busy;
    } stim_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       id_valid, id_is_imm, id_mem_write, id_branch, id_wb_en, id_mem_read;
    logic [4:0] id_src1, id_src2, id_dest;
    logic       exe_br_taken, mem_busy;

    // {hold_pc, bubble_ex, flush_front, freeze_all, state[1:0]}
    wire [5:0]  obs_fw, obs_nf, obs_f3;
    logic [5:0] exp_q[$];
    int         n_cmp = 0;
    int         n_bad = 0;

    always #5 clk = ~clk;

    pipeline_hazard_sequencer #(.FORWARD_EN(1'b1), .FLUSH_CYCLES(2)) dut_fw (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_src1(id_src1), .id_src2(id_src2),
        .id_is_imm(id_is_imm), .id_mem_write(id_mem_write), .id_branch(id_branch),
        .id_dest(id_dest), .id_wb_en(id_wb_en), .id_mem_read(id_mem_read),
        .exe_br_taken(exe_br_taken), .mem_busy(mem_busy),
        .hold_pc(obs_fw[5]), .bubble_ex(obs_fw[4]), .flush_front(obs_fw[3]),
        .freeze_all(obs_fw[2]), .state(obs_fw[1:0]));

    pipeline_hazard_sequencer #(.FORWARD_EN(1'b0), .FLUSH_CYCLES(2)) dut_nf (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_src1(id_src1), .id_src2(id_src2),
        .id_is_imm(id_is_imm), .id_mem_write(id_mem_write), .id_branch(id_branch),
        .id_dest(id_dest), .id_wb_en(id_wb_en), .id_mem_read(id_mem_read),
        .exe_br_taken(exe_br_taken), .mem_busy(mem_busy),
        .hold_pc(obs_nf[5]), .bubble_ex(obs_nf[4]), .flush_front(obs_nf[3]),
        .freeze_all(obs_nf[2]), .state(obs_nf[1:0]));

    pipeline_hazard_sequencer #(.FORWARD_EN(1'b1), .FLUSH_CYCLES(3)) dut_f3 (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_src1(id_src1), .id_src2(id_src2),
        .id_is_imm(id_is_imm), .id_mem_write(id_mem_write), .id_branch(id_branch),
        .id_dest(id_dest), .id_wb_en(id_wb_en), .id_mem_read(id_mem_read),
        .exe_br_taken(exe_br_taken), .mem_busy(mem_busy),
        .hold_pc(obs_f3[5]), .bubble_ex(obs_f3[4]), .flush_front(obs_f3[3]),
        .freeze_all(obs_f3[2]), .state(obs_f3[1:0]));

    function automatic stim_t nop();
        return '0;
    endfunction

    function automatic stim_t alu(input logic [4:0] d, input logic [4:0] a, input logic [4:0] b);
        stim_t s = '0;
        s.valid = 1'b1; s.dest = d; s.s1 = a; s.s2 = b; s.wb = 1'b1;
        return s;
    endfunction

    function automatic stim_t ld(input logic [4:0] d, input logic [4:0] a);
        stim_t s = '0;
        s.valid = 1'b1; s.dest = d; s.s1 = a; s.imm = 1'b1; s.wb = 1'b1; s.mr = 1'b1;
        return s;
    endfunction

    function automatic stim_t imm_op(input logic [4:0] d, input logic [4:0] a, input logic [4:0] b);
        stim_t s = alu(d, a, b);
        s.imm = 1'b1;
        return s;
    endfunction

    function automatic stim_t store(input logic [4:0] a, input logic [4:0] b);
        stim_t s = '0;
        s.valid = 1'b1; s.s1 = a; s.s2 = b; s.imm = 1'b1; s.mw = 1'b1;
        return s;
    endfunction

    function automatic stim_t with_ctl(input stim_t s_in, input logic brt, input logic busy);
        stim_t s = s_in;
        s.brt = brt; s.busy = busy;
        return s;
    endfunction

    function automatic logic [5:0] ex(input logic h, input logic b, input logic f,
                                      input logic z, input logic [1:0] st);
        return {h, b, f, z, st};
    endfunction

    function automatic logic [5:0] pick(input int which);
        case (which)
            0:       return obs_fw;
            1:       return obs_nf;
            default: return obs_f3;
        endcase
    endfunction

    task automatic drive(input stim_t s);
        rst_n        = !s.rst;
        id_valid     = s.valid;
        id_src1      = s.s1;
        id_src2      = s.s2;
        id_is_imm    = s.imm;
        id_mem_write = s.mw;
        id_branch    = s.br;
        id_dest      = s.dest;
        id_wb_en     = s.wb;
        id_mem_read  = s.mr;
        exe_br_taken = s.brt;
        mem_busy     = s.busy;
    endtask

    task automatic do_reset();
        stim_t s = nop();
        s.rst = 1'b1;
        @(posedge clk); #1; drive(s);
        @(posedge clk); #1;
        @(posedge clk); #1; drive(nop());
    endtask

    task automatic test_reset();
        logic [5:0] got;
        stim_t s = with_ctl(ld(5'd3, 5'd1), 1'b1, 1'b1);
        s.rst = 1'b1;
        @(posedge clk); #1; drive(s);
        @(posedge clk); #1;
        @(posedge clk); #1; drive(nop());
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            exp_q.push_back(6'b0);
            got = pick(k);
            n_cmp++;
            if (got !== exp_q.pop_front()) begin
                n_bad++;
                $display("FAIL reset dut%0d: got %b want 000000", k, got);
            end
        end
    endtask

    task automatic test_load_use();
        stim_t s[$];
        logic [5:0] e[$];
        logic [5:0] got, want;
        do_reset();
        s.push_back(ld(5'd3, 5'd1));          e.push_back(ex(0, 0, 0, 0, 2'd0));
        s.push_back(alu(5'd4, 5'd3, 5'd1));   e.push_back(ex(1, 1, 0, 0, 2'd0));
        s.push_back(alu(5'd4, 5'd3, 5'd1));   e.push_back(ex(0, 0, 0, 0, 2'd0));
        s.push_back(alu(5'd5, 5'd4, 5'd4));   e.push_back(ex(0, 0, 0, 0, 2'd0));
        foreach (s[i]) begin
            @(posedge clk); #1; drive(s[i]); exp_q.push_back(e[i]);
            @(negedge clk);
            got = pick(0); want = exp_q.pop_front(); n_cmp++;
            if (got !== want) begin
                n_bad++;
                $display("FAIL load_use row %0d: got %b want %b", i, got, want);
            end
        end
    endtask

    task automatic test_no_false_hazard();
        stim_t s[$];
        logic [5:0] e[$];
        logic [5:0] got, want;
        do_reset();
        s.push_back(alu(5'd0, 5'd1, 5'd2));    e.push_back(ex(0, 0, 0, 0, 2'd0));
        s.push_back(alu(5'd6, 5'd0, 5'd0));    e.push_back(ex(0, 0, 0, 0, 2'd0));
        s.push_back(imm_op(5'd5, 5'd1, 5'd0)); e.push_back(ex(0, 0, 0, 0, 2'd0));
        s.push_back(imm_op(5'd8, 5'd7, 5'd5)); e.push_back(ex(0, 0, 0, 0, 2'd0));
        s.push_back(store(5'd9, 5'd5));        e.push_back(ex(1, 1, 0, 0, 2'd0));
        s.push_back(store(5'd9, 5'd5));        e.push_back(ex(0, 0, 0, 0, 2'd0));
        s.push_back(nop());                    e.push_back(ex(0, 0, 0, 0, 2'd0));
        foreach (s[i]) begin
            @(posedge clk); #1; drive(s[i]); exp_q.push_back(e[i]);
            @(negedge clk);
            got = pick(1); want = exp_q.pop_front(); n_cmp++;
            if (got !== want) begin
                n_bad++;
                $display("FAIL no_false_hazard row %0d: got %b want %b", i, got, want);
            end
        end
    endtask

    task automatic test_no_forward();
        stim_t s[$];
        logic [5:0] e[$];
        logic [5:0] got, want;
        do_reset();
        s.push_back(alu(5'd2, 5'd1, 5'd1));   e.push_back(ex(0, 0, 0, 0, 2'd0));
        s.push_back(alu(5'd6, 5'd2, 5'd2));   e.push_back(ex(1, 1, 0, 0, 2'd0));
        s.push_back(alu(5'd6, 5'd2, 5'd2));   e.push_back(ex(1, 1, 0, 0, 2'd0));
        s.push_back(alu(5'd6, 5'd2, 5'd2));   e.push_back(ex(0, 0, 0, 0, 2'd0));
        s.push_back(alu(5'd2, 5'd1, 5'd1));   e.push_back(ex(0, 0, 0, 0, 2'd0));
        s.push_back(alu(5'd7, 5'd9, 5'd10));  e.push_back(ex(0, 0, 0, 0, 2'd0));
        s.push_back(alu(5'd6, 5'd2, 5'd2));   e.push_back(ex(1, 1, 0, 0, 2'd0));
        s.push_back(alu(5'd6, 5'd2, 5'd2));   e.push_back(ex(0, 0, 0, 0, 2'd0));
        foreach (s[i]) begin
            @(posedge clk); #1; drive(s[i]); exp_q.push_back(e[i]);
            @(negedge clk);
            got = pick(1); want = exp_q.pop_front(); n_cmp++;
            if (got !== want) begin
                n_bad++;
                $display("FAIL no_forward row %0d: got %b want %b", i, got, want);
            end
        end
    endtask

    task automatic test_branch_flush();
        stim_t s[$];
        logic [5:0] e[$];
        logic [5:0] got, want;
        do_reset();
        s.push_back(ld(5'd3, 5'd1));                            e.push_back(ex(0, 0, 0, 0, 2'd0));
        s.push_back(with_ctl(alu(5'd4, 5'd3, 5'd1), 1'b1, 1'b0)); e.push_back(ex(0, 0, 1, 0, 2'd0));
        s.push_back(alu(5'd4, 5'd3, 5'd1));                     e.push_back(ex(0, 0, 1, 0, 2'd1));
        s.push_back(alu(5'd9, 5'd1, 5'd1));                     e.push_back(ex(0, 0, 0, 0, 2'd0));
        foreach (s[i]) begin
            @(posedge clk); #1; drive(s[i]); exp_q.push_back(e[i]);
            @(negedge clk);
            got = pick(0); want = exp_q.pop_front(); n_cmp++;
            if (got !== want) begin
                n_bad++;
                $display("FAIL branch_flush row %0d: got %b want %b", i, got, want);
            end
        end
    endtask

    task automatic test_branch_flush3();
        stim_t s[$];
        logic [5:0] e[$];
        logic [5:0] got, want;
        do_reset();
        s.push_back(with_ctl(nop(), 1'b1, 1'b0)); e.push_back(ex(0, 0, 1, 0, 2'd0));
        s.push_back(alu(5'd1, 5'd2, 5'd3));       e.push_back(ex(0, 0, 1, 0, 2'd1));
        s.push_back(alu(5'd1, 5'd2, 5'd3));       e.push_back(ex(0, 0, 1, 0, 2'd1));
        s.push_back(alu(5'd1, 5'd2, 5'd3));       e.push_back(ex(0, 0, 0, 0, 2'd0));
        foreach (s[i]) begin
            @(posedge clk); #1; drive(s[i]); exp_q.push_back(e[i]);
            @(negedge clk);
            got = pick(2); want = exp_q.pop_front(); n_cmp++;
            if (got !== want) begin
                n_bad++;
                $display("FAIL branch_flush3 row %0d: got %b want %b", i, got, want);
            end
        end
    endtask

    task automatic test_freeze();
        stim_t s[$];
        logic [5:0] e[$];
        logic [5:0] got, want;
        stim_t dep = alu(5'd4, 5'd3, 5'd1);
        do_reset();
        s.push_back(alu(5'd10, 5'd1, 5'd1));                        e.push_back(ex(0, 0, 0, 0, 2'd0));
        s.push_back(with_ctl(alu(5'd11, 5'd10, 5'd10), 1'b0, 1'b1)); e.push_back(ex(1, 0, 0, 1, 2'd0));
        s.push_back(with_ctl(alu(5'd11, 5'd10, 5'd10), 1'b1, 1'b1)); e.push_back(ex(1, 0, 0, 1, 2'd2));
        s.push_back(with_ctl(alu(5'd11, 5'd10, 5'd10), 1'b0, 1'b1)); e.push_back(ex(1, 0, 0, 1, 2'd2));
        s.push_back(with_ctl(alu(5'd11, 5'd10, 5'd10), 1'b0, 1'b1)); e.push_back(ex(1, 0, 0, 1, 2'd2));
        s.push_back(alu(5'd11, 5'd10, 5'd10));                      e.push_back(ex(0, 0, 1, 0, 2'd2));
        s.push_back(alu(5'd12, 5'd1, 5'd1));                        e.push_back(ex(0, 0, 1, 0, 2'd1));
        s.push_back(nop());                                         e.push_back(ex(0, 0, 0, 0, 2'd0));
        s.push_back(ld(5'd3, 5'd1));                                e.push_back(ex(0, 0, 0, 0, 2'd0));
        s.push_back(with_ctl(dep, 1'b0, 1'b1));                     e.push_back(ex(1, 0, 0, 1, 2'd0));
        s.push_back(with_ctl(dep, 1'b0, 1'b1));                     e.push_back(ex(1, 0, 0, 1, 2'd2));
        s.push_back(dep);                                           e.push_back(ex(1, 1, 0, 0, 2'd2));
        s.push_back(dep);                                           e.push_back(ex(0, 0, 0, 0, 2'd0));
        foreach (s[i]) begin
            @(posedge clk); #1; drive(s[i]); exp_q.push_back(e[i]);
            @(negedge clk);
            got = pick(0); want = exp_q.pop_front(); n_cmp++;
            if (got !== want) begin
                n_bad++;
                $display("FAIL freeze row %0d: got %b want %b", i, got, want);
            end
        end
    endtask

    task automatic test_reset_mid_flush();
        stim_t s[$];
        logic [5:0] e[$];
        logic [5:0] got, want;
        stim_t r = nop();
        r.rst = 1'b1;
        do_reset();
        s.push_back(alu(5'd12, 5'd1, 5'd1));                       e.push_back(ex(0, 0, 0, 0, 2'd0));
        s.push_back(with_ctl(alu(5'd13, 5'd1, 5'd1), 1'b1, 1'b0)); e.push_back(ex(0, 0, 1, 0, 2'd0));
        s.push_back(r);                                            e.push_back(ex(0, 0, 1, 0, 2'd1));
        s.push_back(alu(5'd14, 5'd12, 5'd12));                     e.push_back(ex(0, 0, 0, 0, 2'd0));
        s.push_back(alu(5'd15, 5'd12, 5'd13));                     e.push_back(ex(0, 0, 0, 0, 2'd0));
        foreach (s[i]) begin
            @(posedge clk); #1; drive(s[i]); exp_q.push_back(e[i]);
            @(negedge clk);
            got = pick(1); want = exp_q.pop_front(); n_cmp++;
            if (got !== want) begin
                n_bad++;
                $display("FAIL reset_mid_flush row %0d: got %b want %b", i, got, want);
            end
        end
    endtask

    initial begin
        drive(nop());
        rst_n = 1'b0;
        test_reset();
        test_load_use();
        test_no_false_hazard();
        test_no_forward();
        test_branch_flush();
        test_branch_flush3();
        test_freeze();
        test_reset_mid_flush();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
